// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: parses a framed 32-bit word stream (header, frame data, checksum)
// and writes assembled frames to the fabric configuration port.
module cfg_frame_loader #(
  parameter int unsigned FRAME_W  = 33,
  parameter int unsigned N_FRAMES = 64,
  parameter logic [15:0] MAGIC    = 16'hC0F6,
  localparam int unsigned AW      = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [AW-1:0]      cfg_addr,
  output logic [FRAME_W-1:0] cfg_data,
  output logic               cfg_we,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned WPF = (FRAME_W + 31) / 32;
  localparam int unsigned WIW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int unsigned BW  = WPF * 32;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t         state, state_n;
  logic [15:0]    count;
  logic [AW-1:0]  frm_idx;
  logic [WIW-1:0] word_idx;
  logic [31:0]    sum;
  logic [BW-1:0]  frame_buf, frame_next;
  logic           xfer, magic_bad, count_bad, last_word, last_frame;

  assign xfer       = in_valid && in_ready;
  assign magic_bad  = (in_word[31:16] != MAGIC);
  assign count_bad  = (in_word[15:0] == 16'd0) || (32'(in_word[15:0]) > N_FRAMES);
  assign last_word  = (word_idx == WIW'(WPF - 1));
  assign last_frame = (16'(frm_idx) == (count - 16'd1));

  // Frame buffer with the incoming word merged into its slot.
  always_comb begin
    frame_next = frame_buf;
    for (int k = 0; k < int'(WPF); k++) begin
      if (word_idx == WIW'(k)) frame_next[32*k +: 32] = in_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_HEADER;
      S_HEADER: if (xfer) state_n = (magic_bad || count_bad) ? S_ERROR : S_DATA;
      S_DATA:   if (xfer && last_word && last_frame) state_n = S_CHECK;
      S_CHECK:  if (xfer) state_n = (in_word == sum) ? S_DONE : S_ERROR;
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; in_ready/busy track the upcoming state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cfg_we    <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      count     <= 16'd0;
      frm_idx   <= '0;
      word_idx  <= '0;
      sum       <= 32'd0;
      frame_buf <= '0;
    end else begin
      cfg_we   <= 1'b0;
      in_ready <= (state_n == S_HEADER) || (state_n == S_DATA) || (state_n == S_CHECK);
      busy     <= (state_n == S_HEADER) || (state_n == S_DATA) || (state_n == S_CHECK);
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            frm_idx  <= '0;
            word_idx <= '0;
            sum      <= 32'd0;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (magic_bad) begin
              error    <= 1'b1;
              err_code <= 2'd1;
            end else if (count_bad) begin
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              count <= in_word[15:0];
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            sum       <= sum + in_word;
            frame_buf <= frame_next;
            if (last_word) begin
              word_idx <= '0;
              cfg_we   <= 1'b1;
              cfg_addr <= frm_idx;
              cfg_data <= frame_next[FRAME_W-1:0];
              // Hold the index on the final frame so it never wraps.
              if (!last_frame) frm_idx <= frm_idx + AW'(1);
            end else begin
              word_idx <= word_idx + WIW'(1);
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_word == sum) begin
              done <= 1'b1;
            end else begin
              error    <= 1'b1;
              err_code <= 2'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader (FRAME_W=33, N_FRAMES=4) with a stream-level reference model.
module tb_cfg_frame_loader;

  localparam int unsigned FW  = 33;
  localparam int unsigned NF  = 4;
  localparam int unsigned AWT = 2;
  localparam int unsigned EW  = AWT + FW;

  logic          clock = 1'b0;
  logic          reset, start, in_valid, in_ready, cfg_we, busy, done, error;
  logic [31:0]   in_word;
  logic [AWT-1:0] cfg_addr;
  logic [FW-1:0] cfg_data;
  logic [1:0]    err_code;

  cfg_frame_loader #(.FRAME_W(FW), .N_FRAMES(NF), .MAGIC(16'hC0F6)) dut (
    .clock(clock), .reset(reset), .start(start), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [31:0]   stim[$];
  logic [EW-1:0] wq[$];
  logic [EW-1:0] exp_q[$];
  logic [1:0]    exp_code;
  int            exp_consumed, consumed, stalls;
  int            start_at = -1;
  logic          busy_after_start;

  always @(negedge clock) if (cfg_we === 1'b1) wq.push_back({cfg_addr, cfg_data});

  // Stream-level reference: parse header, gather frames, sum data, compare trailer.
  task automatic model();
    logic [31:0] s;
    logic [63:0] fr;
    logic [31:0] hdr;
    int p, cnt;
    exp_q.delete();
    exp_code = 2'd0;
    hdr = stim[0];
    p = 1;
    if (hdr[31:16] != 16'hC0F6) exp_code = 2'd1;
    else begin
      cnt = int'(hdr[15:0]);
      if (cnt == 0 || cnt > int'(NF)) exp_code = 2'd2;
      else begin
        s = 32'd0;
        for (int f = 0; f < cnt; f++) begin
          fr = 64'd0;
          for (int k = 0; k < 2; k++) begin
            fr[32*k +: 32] = stim[p];
            s = s + stim[p];
            p++;
          end
          exp_q.push_back({AWT'(f), fr[FW-1:0]});
        end
        exp_code = (stim[p] == s) ? 2'd0 : 2'd3;
        p++;
      end
    end
    exp_consumed = p;
  endtask

  // Drives stim; gap 0 = continuous, 1 = in_valid toggles, 2 = random gaps.
  task automatic load(input int gap, input bit do_start);
    int idx = 0;
    int tmo = 0;
    bit acc, ph;
    ph = 1'b0;
    stalls = 0;
    wq.delete();
    @(negedge clock);
    if (do_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      busy_after_start = busy;
    end
    while (idx < stim.size() && tmo < 20 && error !== 1'b1) begin
      in_word = stim[idx];
      start = (idx == start_at);
      case (gap)
        0:       in_valid = 1'b1;
        1:       begin ph = ~ph; in_valid = ph; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      acc = in_valid && (in_ready === 1'b1);
      @(negedge clock);
      if (acc) begin idx++; tmo = 0; end
      else begin tmo++; stalls++; end
    end
    in_valid = 1'b0;
    start = 1'b0;
    consumed = idx;
    repeat (2) @(negedge clock);
  endtask

  task automatic set_good(input logic [31:0] trailer);
    stim = '{32'hC0F60002, 32'hDEADBEEF, 32'h00000001, 32'h12345678, 32'h00000000, trailer};
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, cfg_we, cfg_addr, cfg_data, busy, done, error, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got in_ready=%b we=%b addr=%0h data=%0h busy=%b done=%b err=%b code=%0d want all 0",
               in_ready, cfg_we, cfg_addr, cfg_data, busy, done, error, err_code);
    end
  endtask

  task automatic test_good_load();
    set_good(32'hF0E21568);
    load(0, 1'b1);
    checks++; if (busy_after_start !== 1'b1) begin errors++; $display("FAIL good_busy_after_start got %b want 1", busy_after_start); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL good_no_bubbles got stalls=%0d want 0", stalls); end
    checks++;
    if (wq.size() !== 2) begin errors++; $display("FAIL good_write_count got %0d want 2", wq.size()); end
    else begin
      checks++; if (wq[0] !== {2'd0, 33'h1_DEADBEEF}) begin errors++; $display("FAIL good_write0 got %0h want %0h", wq[0], {2'd0, 33'h1_DEADBEEF}); end
      checks++; if (wq[1] !== {2'd1, 33'h0_12345678}) begin errors++; $display("FAIL good_write1 got %0h want %0h", wq[1], {2'd1, 33'h0_12345678}); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done got %b want 1", done); end
    checks++; if (err_code !== 2'd0 || error !== 1'b0) begin errors++; $display("FAIL good_no_error got err=%b code=%0d want 0/0", error, err_code); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL good_idle_after got ready=%b busy=%b want 0/0", in_ready, busy); end
  endtask

  task automatic test_bad_magic();
    stim = '{32'hC0F70001};
    load(0, 1'b1);
    checks++; if (error !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL bad_magic got err=%b code=%0d want 1/1", error, err_code); end
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL bad_magic_writes got %0d want 0", wq.size()); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL bad_magic_flags got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_bad_count();
    logic [31:0] hdrs[2];
    hdrs[0] = 32'hC0F60005;
    hdrs[1] = 32'hC0F60000;
    for (int i = 0; i < 2; i++) begin
      stim = '{hdrs[i], 32'h11111111, 32'h22222222};
      load(0, 1'b1);
      checks++; if (error !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL bad_count[%0d] got err=%b code=%0d want 1/2", i, error, err_code); end
      checks++; if (wq.size() !== 0 || consumed !== 1) begin errors++; $display("FAIL bad_count_writes[%0d] got writes=%0d consumed=%0d want 0/1", i, wq.size(), consumed); end
    end
  endtask

  task automatic test_checksum();
    set_good(32'hF0E21569);
    model();
    load(0, 1'b1);
    checks++; if (wq.size() !== 2 || wq !== exp_q) begin errors++; $display("FAIL csum_writes got %0d writes want %0d matching model", wq.size(), exp_q.size()); end
    checks++; if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0) begin errors++; $display("FAIL csum_error got err=%b code=%0d done=%b want 1/3/0", error, err_code, done); end
  endtask

  task automatic test_backpressure();
    set_good(32'hF0E21568);
    model();
    load(1, 1'b1);
    checks++; if (wq !== exp_q) begin errors++; $display("FAIL bp_writes got %0d writes want %0d matching model", wq.size(), exp_q.size()); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL bp_done got done=%b err=%b want 1/0", done, error); end
  endtask

  task automatic test_reset_midload();
    stim = '{32'hC0F60002, 32'hDEADBEEF, 32'h00000001, 32'h12345678};
    load(0, 1'b1);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, cfg_we, cfg_addr, cfg_data, busy, done, error, err_code} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got ready=%b we=%b addr=%0h data=%0h busy=%b want all 0", in_ready, cfg_we, cfg_addr, cfg_data, busy);
    end
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL midreset_writes got %0d want 1", wq.size()); end
    @(negedge clock) reset = 1'b0;
    set_good(32'hF0E21568);
    model();
    load(0, 1'b1);
    checks++; if (done !== 1'b1 || wq !== exp_q) begin errors++; $display("FAIL midreset_reload got done=%b writes=%0d want 1/%0d", done, wq.size(), exp_q.size()); end
  endtask

  task automatic test_start_during_data();
    set_good(32'hF0E21568);
    model();
    start_at = 2;
    load(0, 1'b1);
    start_at = -1;
    checks++; if (done !== 1'b1 || wq !== exp_q || consumed !== exp_consumed) begin
      errors++; $display("FAIL start_in_data got done=%b writes=%0d consumed=%0d want 1/%0d/%0d", done, wq.size(), consumed, exp_q.size(), exp_consumed);
    end
  endtask

  task automatic test_restart_from_done();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL restart_clear got done=%b busy=%b ready=%b want 0/1/1", done, busy, in_ready); end
    stim = '{32'hC0F60001, 32'hA5A5A5A5, 32'h00000003, 32'hA5A5A5A8};
    model();
    load(0, 1'b0);
    checks++; if (done !== 1'b1 || wq !== exp_q) begin errors++; $display("FAIL restart_load got done=%b writes=%0d want 1/%0d", done, wq.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int cnt, sel;
      logic [31:0] s;
      sel = $urandom_range(0, 9);
      cnt = (sel == 0) ? 0 : (sel == 1) ? 5 : $urandom_range(1, 4);
      stim.delete();
      stim.push_back({(sel == 2) ? 16'hC0F5 : 16'hC0F6, 16'(cnt)});
      s = 32'd0;
      for (int w = 0; w < 2 * cnt; w++) begin
        stim.push_back($urandom);
        s = s + stim[stim.size() - 1];
      end
      stim.push_back((sel == 3) ? s ^ 32'h0000_0100 : s);
      model();
      load(2, 1'b1);
      checks++;
      if (wq !== exp_q || err_code !== exp_code || done !== (exp_code == 2'd0) || error !== (exp_code != 2'd0) || consumed !== exp_consumed) begin
        errors++;
        $display("FAIL random[%0d] got writes=%0d code=%0d done=%b err=%b consumed=%0d want %0d/%0d/%b/%b/%0d",
                 it, wq.size(), err_code, done, error, consumed, exp_q.size(), exp_code, exp_code == 2'd0, exp_code != 2'd0, exp_consumed);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = 32'd0;
    #3 test_reset();
    @(negedge clock) reset = 1'b0;
    test_good_load();
    test_bad_magic();
    test_bad_count();
    test_checksum();
    test_backpressure();
    test_reset_midload();
    test_start_during_data();
    test_restart_from_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
